// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the dual-lane data memory arbiter.
// Lane 0 always carries the older instruction.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;

  typedef logic lane_t;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way chooser: a single requester always wins; on contention
// force_0 or the round-robin pointer selects the winner.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic  req_0,
  input  logic  req_1,
  input  lane_t prio,
  input  logic  force_0,
  output logic  gnt_0,
  output logic  gnt_1
);

  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (req_0 && req_1) begin
      if (force_0 || (prio == 1'b0)) begin
        gnt_0 = 1'b1;
      end else begin
        gnt_1 = 1'b1;
      end
    end else begin
      gnt_0 = req_0;
      gnt_1 = req_1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between two memory-stage lanes; matching
// loads are merged, stores to a shared address keep program order.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              stall_0,
  output logic              stall_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem,
  output logic [CNT_W-1:0]  conflict_count
);

  logic              both;
  logic              same_addr;
  logic              dual;
  logic              force_0;
  logic              pick_0;
  logic              pick_1;

  lane_t             prio_q;
  lane_t             prio_d;
  logic              rvalid_0_q;
  logic              rvalid_0_d;
  logic              rvalid_1_q;
  logic              rvalid_1_d;
  logic [DATA_W-1:0] rdata_0_q;
  logic [DATA_W-1:0] rdata_0_d;
  logic [DATA_W-1:0] rdata_1_q;
  logic [DATA_W-1:0] rdata_1_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  assign both      = req_0 & req_1;
  assign same_addr = (addr_0 == addr_1);
  assign dual      = both & same_addr & ~we_0 & ~we_1;
  // A store on a shared address must not overtake the older lane.
  assign force_0   = same_addr & (we_0 | we_1);

  rr_pick2 u_pick (
    .req_0   (req_0),
    .req_1   (req_1),
    .prio    (prio_q),
    .force_0 (force_0),
    .gnt_0   (pick_0),
    .gnt_1   (pick_1)
  );

  assign gnt_0   = pick_0 | dual;
  assign gnt_1   = pick_1 | dual;
  assign stall_0 = req_0 & ~gnt_0;
  assign stall_1 = req_1 & ~gnt_1;

  always_comb begin
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    if (gnt_0) begin
      address_dmem = addr_0;
      data         = wdata_0;
      wren         = we_0 & ~reset;
    end else if (gnt_1) begin
      address_dmem = addr_1;
      data         = wdata_1;
      wren         = we_1 & ~reset;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (both && (gnt_0 ^ gnt_1)) begin
      prio_d = gnt_0 ? 1'b1 : 1'b0;
    end
    rvalid_0_d = gnt_0 & ~we_0;
    rvalid_1_d = gnt_1 & ~we_1;
    rdata_0_d  = rvalid_0_d ? q_dmem : rdata_0_q;
    rdata_1_d  = rvalid_1_d ? q_dmem : rdata_1_q;
    cnt_d      = cnt_q;
    if ((stall_0 | stall_1) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q     <= 1'b0;
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
      rdata_0_q  <= '0;
      rdata_1_q  <= '0;
      cnt_q      <= '0;
    end else begin
      prio_q     <= prio_d;
      rvalid_0_q <= rvalid_0_d;
      rvalid_1_q <= rvalid_1_d;
      rdata_0_q  <= rdata_0_d;
      rdata_1_q  <= rdata_1_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rvalid_0       = rvalid_0_q;
  assign rvalid_1       = rvalid_1_q;
  assign rdata_0        = rdata_0_q;
  assign rdata_1        = rdata_1_q;
  assign conflict_count = cnt_q;

endmodule
